// File: rtl/digit_roi_sequencer.sv
// Walks the row/column border RAMs, issues one ROI per character cell to a recognizer and reports its result.
// Optional WAIT watchdog is enabled by defining ROI_TIMEOUT_EN.
module digit_roi_sequencer #(
  parameter int unsigned NUM_ROW = 1,
  parameter int unsigned NUM_COL = 4,
  parameter int unsigned H_PIXEL = 480,
  parameter int unsigned V_PIXEL = 272,
  parameter int unsigned DEPBIT  = 10,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              project_done,
  input  logic [3:0]        num_col,
  input  logic [3:0]        num_row,
  output logic [DEPBIT-1:0] col_border_addr_rd,
  input  logic [DEPBIT-1:0] col_border_data_rd,
  output logic [DEPBIT-1:0] row_border_addr_rd,
  input  logic [DEPBIT-1:0] row_border_data_rd,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [DEPBIT-1:0] box_x_min,
  output logic [DEPBIT-1:0] box_x_max,
  output logic [DEPBIT-1:0] box_y_min,
  output logic [DEPBIT-1:0] box_y_max,
  output logic [3:0]        box_idx,
  input  logic              rec_done,
  input  logic [3:0]        rec_digit,
  output logic              result_valid,
  output logic [3:0]        result_idx,
  output logic [3:0]        result_digit,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              box_err,
  output logic              timeout_err
);
  localparam int unsigned CW = 5;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [DEPBIT-1:0] H_MAX = DEPBIT'(H_PIXEL - 1);
  localparam logic [DEPBIT-1:0] V_MAX = DEPBIT'(V_PIXEL - 1);

  typedef enum logic [2:0] {IDLE, RD_ROW, RD_COL, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t state, state_d;
  logic [1:0] ph, ph_d;
  logic proj_q;
  logic [CW-1:0] eff_col, eff_col_d, eff_row, eff_row_d;
  logic [3:0] r, r_d, c, c_d;
  logic [TW-1:0] wait_cnt, wait_cnt_d;
  logic [DEPBIT-1:0] col_addr_d, row_addr_d, x_min_d, x_max_d, y_min_d, y_max_d;
  logic [3:0] box_idx_d, result_idx_d, result_digit_d;
  logic rec_valid_d, result_valid_d, seq_busy_d, seq_done_d, box_err_d, timeout_err_d;

  logic [CW-1:0] eff_col_c, eff_row_c;
  logic [DEPBIT-1:0] row_lo_c, row_hi_c, col_lo_c, col_hi_c;
  logic [3:0] idx_c;
  logic start_c;

  // Out-of-frame min is an underflow wrap; out-of-frame max saturates at the frame edge.
  assign row_lo_c  = (row_border_data_rd > V_MAX) ? '0 : row_border_data_rd;
  assign row_hi_c  = (row_border_data_rd > V_MAX) ? V_MAX : row_border_data_rd;
  assign col_lo_c  = (col_border_data_rd > H_MAX) ? '0 : col_border_data_rd;
  assign col_hi_c  = (col_border_data_rd > H_MAX) ? H_MAX : col_border_data_rd;
  assign eff_col_c = ({1'b0, num_col} > CW'(NUM_COL)) ? CW'(NUM_COL) : {1'b0, num_col};
  assign eff_row_c = ({1'b0, num_row} > CW'(NUM_ROW)) ? CW'(NUM_ROW) : {1'b0, num_row};
  assign idx_c     = 4'(32'(r) * NUM_COL + 32'(c));
  assign start_c   = project_done & ~proj_q;

  always_comb begin
    state_d        = state;
    ph_d           = ph;
    eff_col_d      = eff_col;
    eff_row_d      = eff_row;
    r_d            = r;
    c_d            = c;
    wait_cnt_d     = wait_cnt;
    col_addr_d     = col_border_addr_rd;
    row_addr_d     = row_border_addr_rd;
    x_min_d        = box_x_min;
    x_max_d        = box_x_max;
    y_min_d        = box_y_min;
    y_max_d        = box_y_max;
    box_idx_d      = box_idx;
    rec_valid_d    = rec_valid;
    result_valid_d = 1'b0;
    result_idx_d   = result_idx;
    result_digit_d = result_digit;
    box_err_d      = box_err;
    timeout_err_d  = timeout_err;
    case (state)
      IDLE: if (start_c) begin
        eff_col_d     = eff_col_c;
        eff_row_d     = eff_row_c;
        r_d           = '0;
        c_d           = '0;
        box_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        if (eff_col_c == '0 || eff_row_c == '0) begin
          state_d = DONE;
        end else begin
          state_d    = RD_ROW;
          ph_d       = '0;
          row_addr_d = DEPBIT'(1);
        end
      end
      RD_ROW: case (ph)
        2'd0:    begin row_addr_d = row_border_addr_rd + DEPBIT'(1); ph_d = 2'd1; end
        2'd1:    begin y_min_d = row_lo_c; ph_d = 2'd2; end
        default: begin
          y_max_d    = row_hi_c;
          ph_d       = '0;
          col_addr_d = DEPBIT'({c, 1'b1});
          state_d    = RD_COL;
        end
      endcase
      RD_COL: case (ph)
        2'd0:    begin col_addr_d = col_border_addr_rd + DEPBIT'(1); ph_d = 2'd1; end
        2'd1:    begin x_min_d = col_lo_c; ph_d = 2'd2; end
        default: begin
          x_max_d   = col_hi_c;
          box_idx_d = idx_c;
          ph_d      = '0;
          // Inverted box on either axis is reported instead of issued.
          if (box_x_min > col_hi_c || box_y_min > box_y_max) begin
            box_err_d      = 1'b1;
            result_valid_d = 1'b1;
            result_idx_d   = idx_c;
            result_digit_d = 4'hE;
            state_d        = NEXT;
          end else begin
            rec_valid_d = 1'b1;
            state_d     = ISSUE;
          end
        end
      endcase
      ISSUE: if (rec_ready) begin
        rec_valid_d = 1'b0;
        wait_cnt_d  = '0;
        state_d     = WAIT;
      end
      WAIT: if (rec_done) begin
        result_valid_d = 1'b1;
        result_idx_d   = box_idx;
        result_digit_d = rec_digit;
        state_d        = NEXT;
      end else begin
        if (wait_cnt != TW'(TIMEOUT)) wait_cnt_d = wait_cnt + TW'(1);
`ifdef ROI_TIMEOUT_EN
        if (wait_cnt == TW'(TIMEOUT - 1)) begin
          result_valid_d = 1'b1;
          result_idx_d   = box_idx;
          result_digit_d = 4'hF;
          timeout_err_d  = 1'b1;
          state_d        = NEXT;
        end
`endif
      end
      NEXT: if ({1'b0, c} + CW'(1) < eff_col) begin
        c_d        = c + 4'd1;
        col_addr_d = DEPBIT'({c + 4'd1, 1'b1});
        ph_d       = '0;
        state_d    = RD_COL;
      end else if ({1'b0, r} + CW'(1) < eff_row) begin
        r_d        = r + 4'd1;
        c_d        = '0;
        row_addr_d = DEPBIT'({r + 4'd1, 1'b1});
        ph_d       = '0;
        state_d    = RD_ROW;
      end else begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    seq_done_d = (state_d == DONE);
    seq_busy_d = (state_d != IDLE);
  end

  // proj_q resets high so a level already present out of reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      ph                 <= '0;
      proj_q             <= 1'b1;
      eff_col            <= '0;
      eff_row            <= '0;
      r                  <= '0;
      c                  <= '0;
      wait_cnt           <= '0;
      col_border_addr_rd <= '0;
      row_border_addr_rd <= '0;
      box_x_min          <= '0;
      box_x_max          <= '0;
      box_y_min          <= '0;
      box_y_max          <= '0;
      box_idx            <= '0;
      rec_valid          <= 1'b0;
      result_valid       <= 1'b0;
      result_idx         <= '0;
      result_digit       <= '0;
      seq_busy           <= 1'b0;
      seq_done           <= 1'b0;
      box_err            <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      state              <= state_d;
      ph                 <= ph_d;
      proj_q             <= project_done;
      eff_col            <= eff_col_d;
      eff_row            <= eff_row_d;
      r                  <= r_d;
      c                  <= c_d;
      wait_cnt           <= wait_cnt_d;
      col_border_addr_rd <= col_addr_d;
      row_border_addr_rd <= row_addr_d;
      box_x_min          <= x_min_d;
      box_x_max          <= x_max_d;
      box_y_min          <= y_min_d;
      box_y_max          <= y_max_d;
      box_idx            <= box_idx_d;
      rec_valid          <= rec_valid_d;
      result_valid       <= result_valid_d;
      result_idx         <= result_idx_d;
      result_digit       <= result_digit_d;
      seq_busy           <= seq_busy_d;
      seq_done           <= seq_done_d;
      box_err            <= box_err_d;
      timeout_err        <= timeout_err_d;
    end
  end
endmodule

// File: tb/tb_digit_roi_sequencer.sv
// Bench for digit_roi_sequencer: border RAM and recognizer models plus a box-list reference model.
module tb_digit_roi_sequencer;
  localparam int NR = 2, NC = 4, HP = 480, VP = 272, DB = 10, TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic project_done = 1'b1;
  logic [3:0] num_col = 4'd4, num_row = 4'd1;
  logic [DB-1:0] col_addr, row_addr, col_data, row_data;
  logic rec_valid, rec_ready = 1'b0, rec_done = 1'b0;
  logic [3:0] rec_digit = 4'd0;
  logic [DB-1:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [3:0] box_idx, result_idx, result_digit;
  logic result_valid, seq_busy, seq_done, box_err, timeout_err;

  digit_roi_sequencer #(.NUM_ROW(NR), .NUM_COL(NC), .H_PIXEL(HP), .V_PIXEL(VP),
                        .DEPBIT(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .project_done(project_done), .num_col(num_col), .num_row(num_row),
    .col_border_addr_rd(col_addr), .col_border_data_rd(col_data),
    .row_border_addr_rd(row_addr), .row_border_data_rd(row_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
    .box_idx(box_idx), .rec_done(rec_done), .rec_digit(rec_digit),
    .result_valid(result_valid), .result_idx(result_idx), .result_digit(result_digit),
    .seq_busy(seq_busy), .seq_done(seq_done), .box_err(box_err), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  logic [DB-1:0] col_ram [0:1023];
  logic [DB-1:0] row_ram [0:1023];
  always @(posedge clk) begin
    col_data <= col_ram[col_addr];
    row_data <= row_ram[row_addr];
  end

  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, valid_cycles = 0, low_cnt = 0, ready_hold = 0;
  int pend = -1, pend_idx = 0, xfer_cyc = 0;
  bit resp_en = 1'b1, unstable = 1'b0, prev_v = 1'b0;
  logic [63:0] prev_box;
  int ans [16];
  int res_idx_q[$], res_dig_q[$], res_cyc_q[$];
  logic [63:0] xfer_q[$];
  int exp_idx[$], exp_dig[$];
  logic [63:0] exp_box[$];
  bit exp_err;

  wire [63:0] box_now = {20'd0, box_idx, box_x_min, box_x_max, box_y_min, box_y_max};

  // Recognizer: samples outputs mid-cycle, then drives ready/done for the coming edge.
  always @(negedge clk) begin
    cyc++;
    rec_done = 1'b0;
    if (rst) begin
      rec_ready = 1'b0; low_cnt = 0; pend = -1; prev_v = 1'b0;
    end else begin
      if (result_valid) begin
        res_idx_q.push_back(int'(result_idx));
        res_dig_q.push_back(int'(result_digit));
        res_cyc_q.push_back(cyc);
      end
      if (seq_done) done_cnt++;
      if (rec_valid) begin
        valid_cycles++;
        if (prev_v && box_now != prev_box) unstable = 1'b1;
        if (low_cnt >= ready_hold) begin
          rec_ready = 1'b1;
          xfer_q.push_back(box_now);
          xfer_cyc = cyc;
          low_cnt = 0;
          prev_v = 1'b0;
          if (resp_en) begin pend = 5; pend_idx = int'(box_idx); end
        end else begin
          rec_ready = 1'b0; low_cnt++; prev_v = 1'b1; prev_box = box_now;
        end
      end else begin
        rec_ready = 1'b0; prev_v = 1'b0;
      end
      if (pend > 0) pend--;
      else if (pend == 0) begin rec_done = 1'b1; rec_digit = 4'(ans[pend_idx]); pend = -1; end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    res_idx_q.delete(); res_dig_q.delete(); res_cyc_q.delete(); xfer_q.delete();
    done_cnt = 0; valid_cycles = 0; unstable = 1'b0;
  endtask

  task automatic start(input int ncol, input int nrow);
    num_col = 4'(ncol); num_row = 4'(nrow);
    clear_obs();
    project_done = 1'b0; tick(); project_done = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check({tag, " seq_done_seen"}, 64'(done_cnt > 0), 64'd1);
    tick();
  endtask

  // Reference: enumerate cells row-major with the clamp and skip rules.
  task automatic build_model(input int ncol, input int nrow);
    int ec, er, xmn, xmx, ymn, ymx, idx;
    exp_idx.delete(); exp_dig.delete(); exp_box.delete(); exp_err = 1'b0;
    ec = (ncol < NC) ? ncol : NC;
    er = (nrow < NR) ? nrow : NR;
    for (int r = 0; r < er; r++) begin
      ymn = int'(row_ram[2*r+1]); if (ymn >= VP) ymn = 0;
      ymx = int'(row_ram[2*r+2]); if (ymx > VP-1) ymx = VP-1;
      for (int c = 0; c < ec; c++) begin
        xmn = int'(col_ram[2*c+1]); if (xmn >= HP) xmn = 0;
        xmx = int'(col_ram[2*c+2]); if (xmx > HP-1) xmx = HP-1;
        idx = r*NC + c;
        exp_idx.push_back(idx);
        if (xmn > xmx || ymn > ymx) begin
          exp_dig.push_back(14); exp_err = 1'b1;
        end else begin
          exp_dig.push_back(ans[idx]);
          exp_box.push_back({20'd0, 4'(idx), 10'(xmn), 10'(xmx), 10'(ymn), 10'(ymx)});
        end
      end
    end
  endtask

  task automatic compare_run(input string tag);
    check({tag, " n_results"}, 64'(res_idx_q.size()), 64'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < res_idx_q.size(); i++) begin
      check({tag, " result_idx"}, 64'(res_idx_q[i]), 64'(exp_idx[i]));
      check({tag, " result_digit"}, 64'(res_dig_q[i]), 64'(exp_dig[i]));
    end
    check({tag, " n_boxes"}, 64'(xfer_q.size()), 64'(exp_box.size()));
    for (int i = 0; i < exp_box.size() && i < xfer_q.size(); i++)
      check({tag, " box"}, xfer_q[i], exp_box[i]);
    check({tag, " box_err"}, 64'(box_err), 64'(exp_err));
    check({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
    check({tag, " idle_after"}, 64'(seq_busy), 64'd0);
  endtask

  task automatic full_run(input string tag, input int ncol, input int nrow);
    build_model(ncol, nrow);
    start(ncol, nrow);
    wait_done(tag, 2000);
    compare_run(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " zeroA"}, 64'({col_addr, row_addr, box_x_min, box_x_max, box_y_min}), 64'd0);
    check({tag, " zeroB"}, 64'({box_y_max, box_idx, rec_valid, result_valid, result_idx,
                                result_digit, seq_busy, seq_done, box_err, timeout_err}), 64'd0);
  endtask

  task automatic base_ram();
    for (int i = 0; i < 1024; i++) begin col_ram[i] = '0; row_ram[i] = '0; end
    col_ram[1] = 10;  col_ram[2] = 40;  col_ram[3] = 60;  col_ram[4] = 90;
    col_ram[5] = 110; col_ram[6] = 140; col_ram[7] = 160; col_ram[8] = 190;
    row_ram[1] = 20;  row_ram[2] = 80;  row_ram[3] = 120; row_ram[4] = 200;
  endtask

  function automatic int rand_pair_val(input int lim, input bit is_max, input int base);
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return int'($urandom_range(lim, 1023));
    if (sel == 1 && !is_max) return base + int'($urandom_range(50, 200));
    return is_max ? base + int'($urandom_range(0, 120)) : int'($urandom_range(0, lim - 1));
  endfunction

  initial begin
    int lo, hi;
    for (int i = 0; i < 16; i++) ans[i] = i;
    base_ram();
    repeat (3) tick();
    check_all_zero("in_reset");
    rst = 1'b0;
    // project_done already high out of reset must not start a run
    repeat (10) tick();
    check("no_run_from_level busy", 64'(seq_busy), 64'd0);
    check("no_run_from_level done", 64'(done_cnt), 64'd0);

    full_run("basic", 4, 1);
    check("basic n4", 64'(res_idx_q.size()), 64'd4);

    base_ram(); col_ram[1] = 5; col_ram[2] = 600; row_ram[1] = 1022; row_ram[2] = 100;
    full_run("clamp", 1, 1);
    check("clamp box", (xfer_q.size() > 0) ? xfer_q[0] : 64'hDEAD,
          {20'd0, 4'd0, 10'd5, 10'd479, 10'd0, 10'd100});

    base_ram(); col_ram[3] = 200; col_ram[4] = 150;
    full_run("inverted", 4, 1);
    check("inverted n_boxes", 64'(xfer_q.size()), 64'd3);
    check("inverted box_err", 64'(box_err), 64'd1);

    base_ram(); ready_hold = 20;
    build_model(1, 1);
    start(1, 1);
    repeat (4) tick();
    project_done = 1'b0; tick(); project_done = 1'b1;
    wait_done("stall", 2000);
    compare_run("stall");
    check("stall valid_cycles", 64'(valid_cycles), 64'd21);
    check("stall stable", 64'(unstable), 64'd0);
    repeat (30) tick();
    check("busy_edge_ignored", 64'(done_cnt), 64'd1);
    ready_hold = 0;

    start(0, 1);
    tick();
    check("zero_col seq_done", 64'(seq_done), 64'd1);
    tick();
    check("zero_col no_valid", 64'(valid_cycles), 64'd0);
    check("zero_col done_cnt", 64'(done_cnt), 64'd1);

    full_run("over_col", 9, 1);
    check("over_col n_boxes", 64'(xfer_q.size()), 64'd4);

    for (int t = 0; t < 15; t++) begin
      for (int k = 0; k < 4; k++) begin
        lo = rand_pair_val(HP, 1'b0, 0);
        hi = rand_pair_val(HP, 1'b1, (lo < HP) ? lo : 0);
        col_ram[2*k+1] = 10'(lo); col_ram[2*k+2] = 10'(hi);
      end
      for (int k = 0; k < 2; k++) begin
        lo = rand_pair_val(VP, 1'b0, 0);
        hi = rand_pair_val(VP, 1'b1, (lo < VP) ? lo : 0);
        row_ram[2*k+1] = 10'(lo); row_ram[2*k+2] = 10'(hi);
      end
      for (int i = 0; i < 16; i++) ans[i] = int'($urandom_range(0, 9));
      ready_hold = int'($urandom_range(0, 3));
      full_run("random", int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
    end
    ready_hold = 0;

    base_ram(); resp_en = 1'b0;
`ifdef ROI_TIMEOUT_EN
    start(1, 1);
    wait_done("timeout", 2000);
    check("timeout n_results", 64'(res_idx_q.size()), 64'd1);
    check("timeout digit", (res_dig_q.size() > 0) ? 64'(res_dig_q[0]) : 64'hDEAD, 64'hF);
    check("timeout latency", (res_cyc_q.size() > 0 &&
          res_cyc_q[0] - xfer_cyc >= TO && res_cyc_q[0] - xfer_cyc <= TO + 2) ? 64'd1 : 64'd0, 64'd1);
    check("timeout_err", 64'(timeout_err), 64'd1);
    start(1, 1);
    for (int i = 0; i < 200 && xfer_q.size() == 0; i++) tick();
    repeat (5) tick();
`else
    start(1, 1);
    repeat (200) tick();
    check("no_timeout n_results", 64'(res_idx_q.size()), 64'd0);
    check("no_timeout err", 64'(timeout_err), 64'd0);
`endif
    check("stuck_in_wait busy", 64'(seq_busy), 64'd1);
    check("stuck_in_wait xfer", 64'(xfer_q.size()), 64'd1);
    rst = 1'b1;
    tick();
    check_all_zero("mid_wait_reset");
    rst = 1'b0; resp_en = 1'b1;
    tick();
    full_run("after_reset", 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
